// File: rtl/adc_pkg.sv
// Shared constants, state encoding and address-bit helper for the serial ADC sequencer.
package adc_pkg;

  localparam int ADC_DATLEN = 12;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS  = 4;
  localparam int CH_W       = 3;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CSLOW = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    CSLOW = ST_CSLOW,
    SHIFT = ST_SHIFT,
    GAP   = ST_GAP
  } state_t;

  // Address bits go out MSB first in periods 1..CH_W; period 0 and the data periods drive 0.
  function automatic logic addr_bit(input logic [BIT_W-1:0] k, input logic [CH_W-1:0] ch);
    logic b;
    b = 1'b0;
    for (int i = 1; i <= CH_W; i++) begin
      if (k == BIT_W'(i)) b = ch[CH_W-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/adc_sclk_div.sv
// Serial clock divider: while run is high, sclk toggles every CLK_DIV cycles starting with a fall;
// fall_tick / rise_tick flag the cycle whose closing edge moves sclk.
module adc_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign tick      = (cnt == CNT_W'(CLK_DIV - 1));
  assign fall_tick = tick & sclk;
  assign rise_tick = tick & ~sclk;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!run) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (tick) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_sequencer.sv
// Framed serial ADC controller: scans enabled channels round-robin and hands each 12-bit
// sample, tagged with its channel, to the consumer over a valid/ready handshake.
module adc_sequencer
  import adc_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic                  cs_n,
  output logic                  sclk,
  output logic                  din,
  input  logic                  dout,
  output logic [ADC_DATLEN-1:0] out_data,
  output logic [CH_W-1:0]       out_ch,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int GAP_W = $clog2(CLK_DIV);

  state_t                state, state_n;
  logic                  fall_tick, rise_tick, run;
  logic                  start, frame_end, gap_done;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [CH_W-1:0]       cur_ch, last_ch, next_ch;
  logic [ADC_DATLEN-1:0] shreg;

  // Lowest enabled channel strictly above last, wrapping to 0.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                              input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last) + i) % NUM_CH;
      if (!found && mask[idx]) begin
        pick  = CH_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign next_ch   = rr_pick(ch_mask, last_ch);
  assign start     = (state == IDLE) && enable && (|ch_mask) && !out_valid;
  assign frame_end = (state == SHIFT) && fall_tick && (bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign gap_done  = (state == GAP) && (gap_cnt == GAP_W'(CLK_DIV - 1));
  assign bit_nxt   = bit_cnt + 1'b1;
  assign busy      = (state != IDLE);

  // The last fall tick of the frame ends the frame instead, so sclk stays high into GAP.
  assign run = (state == CSLOW) || ((state == SHIFT) && !frame_end);

  adc_sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .sclk      (sclk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)     state_n = CSLOW;
      CSLOW:   if (fall_tick) state_n = SHIFT;
      SHIFT:   if (frame_end) state_n = GAP;
      GAP:     if (gap_done)  state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_n      <= 1'b1;
      din       <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      cur_ch    <= '0;
      last_ch   <= CH_W'(NUM_CH - 1);
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (start) begin
        cur_ch  <= next_ch;
        last_ch <= next_ch;
        cs_n    <= 1'b0;
        bit_cnt <= '0;
      end

      if ((state == SHIFT) && rise_tick && (bit_cnt >= BIT_W'(ADDR_BITS)))
        shreg <= {shreg[ADC_DATLEN-2:0], dout};

      if (frame_end) begin
        out_data  <= shreg;
        out_ch    <= cur_ch;
        out_valid <= 1'b1;
        cs_n      <= 1'b1;
        din       <= 1'b0;
        gap_cnt   <= '0;
      end else if ((state == SHIFT) && fall_tick) begin
        bit_cnt <= bit_nxt;
        din     <= addr_bit(bit_nxt, cur_ch);
      end

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule
